branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the pipelined core, replacing the fixed stall-on-B/BR decode policy. Fetch looks up the current PC in a direct-mapped branch target buffer with saturating counters and gets a predicted next PC in the same cycle. Decode reports each resolved branch back. The block updates its table, flags mispredictions and supplies the redirect PC used to flush IF/ID.

---
 rtl/branch_predictor.sv | 111 +++++++++++
 tb/tb_branch_predictor.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor with saturating counters, combinational lookup and resolve.
// Define BP_STATS_EN to add saturating resolved-branch and misprediction counters.
module branch_predictor #(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [ADDR_W-1:0] lk_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
`ifdef BP_STATS_EN
    output logic [15:0]       stat_upd,
    output logic [15:0]       stat_miss,
`endif
    output logic [ADDR_W-1:0] redirect_pc
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 1;
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_MAX     = '1;

    logic              entry_valid  [ENTRIES];
    logic [TAG_W-1:0]  entry_tag    [ENTRIES];
    logic [ADDR_W-1:0] entry_target [ENTRIES];
    logic [CTR_W-1:0]  entry_ctr    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] c);
        return (c == CTR_MAX) ? c : c + CTR_W'(1);
    endfunction

    function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] c);
        return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    assign lk_idx  = lk_pc[IDX_W:1];
    assign lk_tag  = lk_pc[ADDR_W-1:IDX_W+1];
    assign upd_idx = upd_pc[IDX_W:1];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W+1];
    assign upd_hit = entry_valid[upd_idx] && (entry_tag[upd_idx] == upd_tag);

    // Lookup is forced to a miss while rst is high, even though the table clears only at the edge.
    always_comb begin
        lk_hit    = !rst && entry_valid[lk_idx] && (entry_tag[lk_idx] == lk_tag);
        lk_taken  = lk_hit && entry_ctr[lk_idx][CTR_W-1];
        lk_target = lk_taken ? entry_target[lk_idx] : lk_pc + ADDR_W'(2);
    end

    always_comb begin
        mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                    (upd_taken && (upd_target != upd_pred_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_valid[i] <= 1'b0;
                entry_ctr[i]   <= CTR_WEAK_NT;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                entry_ctr[upd_idx] <= upd_taken ? sat_inc(entry_ctr[upd_idx])
                                                : sat_dec(entry_ctr[upd_idx]);
            end else if (upd_taken) begin
                entry_valid[upd_idx] <= 1'b1;
                entry_ctr[upd_idx]   <= CTR_WEAK_T;
            end
        end
    end

    // Tag and target are data: written on any taken update, never reset.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            entry_tag[upd_idx]    <= upd_tag;
            entry_target[upd_idx] <= upd_target;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_upd  <= '0;
            stat_miss <= '0;
        end else begin
            if (upd_valid && stat_upd != 16'hFFFF)
                stat_upd <= stat_upd + 16'd1;
            if (mispredict && stat_miss != 16'hFFFF)
                stat_miss <= stat_miss + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor (default parameters), with extra
// hand-written sequences for reset behaviour and the optional BP_STATS_EN counters.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] lk_pc;
    logic        lk_hit;
    logic        lk_taken;
    logic [15:0] lk_target;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_pred_taken;
    logic [15:0] upd_pred_target;
    logic        mispredict;
    logic [15:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [15:0] stat_upd;
    logic [15:0] stat_miss;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .lk_pc           (lk_pc),
        .lk_hit          (lk_hit),
        .lk_taken        (lk_taken),
        .lk_target       (lk_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
`ifdef BP_STATS_EN
        .stat_upd        (stat_upd),
        .stat_miss       (stat_miss),
`endif
        .redirect_pc     (redirect_pc)
    );

    typedef struct {
        logic        rst;
        logic [15:0] lk;
        logic        uv;
        logic [15:0] upc;
        logic        ut;
        logic [15:0] utgt;
        logic        upt;
        logic [15:0] uptgt;
        logic        hit;
        logic        tk;
        logic [15:0] tgt;
        logic        mis;
        logic [15:0] redir;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic [15:0] lk, input logic uv,
                                input logic [15:0] upc, input logic ut, input logic [15:0] utgt,
                                input logic upt, input logic [15:0] uptgt,
                                input logic hit, input logic tk, input logic [15:0] tgt,
                                input logic mis, input logic [15:0] redir);
        vec_t v;
        v.rst = r;   v.lk = lk;     v.uv = uv;   v.upc = upc; v.ut = ut;
        v.utgt = utgt; v.upt = upt; v.uptgt = uptgt;
        v.hit = hit; v.tk = tk;     v.tgt = tgt; v.mis = mis; v.redir = redir;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [15:0] lk, input logic uv,
                         input logic [15:0] upc, input logic ut, input logic [15:0] utgt,
                         input logic upt, input logic [15:0] uptgt);
        @(negedge clk);
        rst = r; lk_pc = lk; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
        #1;
    endtask

    initial begin
        rst = 1'b1; lk_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;

        // rst, lk, uv, upc, ut, utgt, upt, uptgt | hit, tk, tgt, mis, redir
        vq.push_back(mk(1, 16'h0010, 1, 16'h0010, 1, 16'h0040, 0, 16'h0012, 0, 0, 16'h0012, 1, 16'h0040));
        vq.push_back(mk(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0012, 0, 16'h0002));
        vq.push_back(mk(0, 16'h0010, 1, 16'h0010, 1, 16'h0040, 0, 16'h0012, 0, 0, 16'h0012, 1, 16'h0040));
        vq.push_back(mk(0, 16'h0010, 1, 16'h0010, 0, 16'h0000, 1, 16'h0040, 1, 1, 16'h0040, 1, 16'h0012));
        vq.push_back(mk(0, 16'h0010, 1, 16'h0010, 0, 16'h0000, 0, 16'h0012, 1, 0, 16'h0012, 0, 16'h0012));
        vq.push_back(mk(0, 16'h0010, 1, 16'h0010, 0, 16'h0000, 0, 16'h0012, 1, 0, 16'h0012, 0, 16'h0012));
        vq.push_back(mk(0, 16'h0010, 1, 16'h0010, 0, 16'h0000, 0, 16'h0012, 1, 0, 16'h0012, 0, 16'h0012));
        vq.push_back(mk(0, 16'h0010, 1, 16'h0010, 0, 16'h0000, 0, 16'h0012, 1, 0, 16'h0012, 0, 16'h0012));
        vq.push_back(mk(0, 16'h0010, 1, 16'h0010, 1, 16'h0040, 0, 16'h0012, 1, 0, 16'h0012, 1, 16'h0040));
        vq.push_back(mk(0, 16'h0010, 1, 16'h0010, 1, 16'h0040, 0, 16'h0012, 1, 0, 16'h0012, 1, 16'h0040));
        vq.push_back(mk(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0002));
        // alias 0x0030 onto index 8
        vq.push_back(mk(0, 16'h0030, 1, 16'h0030, 1, 16'h0100, 0, 16'h0032, 0, 0, 16'h0032, 1, 16'h0100));
        vq.push_back(mk(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0012, 0, 16'h0002));
        vq.push_back(mk(0, 16'h0030, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0100, 0, 16'h0002));
        // same-cycle lookup/update, then wrong-target prediction
        vq.push_back(mk(0, 16'h0020, 1, 16'h0020, 1, 16'h0050, 0, 16'h0022, 0, 0, 16'h0022, 1, 16'h0050));
        vq.push_back(mk(0, 16'h0020, 1, 16'h0020, 1, 16'h0060, 1, 16'h0050, 1, 1, 16'h0050, 1, 16'h0060));
        vq.push_back(mk(0, 16'h0020, 1, 16'h0020, 1, 16'h0060, 1, 16'h0060, 1, 1, 16'h0060, 0, 16'h0060));
        vq.push_back(mk(0, 16'h0020, 1, 16'h0020, 0, 16'h0000, 1, 16'h0060, 1, 1, 16'h0060, 1, 16'h0022));
        vq.push_back(mk(0, 16'h0020, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0060, 0, 16'h0002));
        // wrap-around and miss-not-taken
        vq.push_back(mk(0, 16'hFFFE, 1, 16'hFFFE, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000));
        vq.push_back(mk(0, 16'hFFFE, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0002));
        // mid-sequence reset with a concurrent (discarded) update
        vq.push_back(mk(1, 16'h0020, 1, 16'h0020, 1, 16'h0070, 1, 16'h0060, 0, 0, 16'h0022, 1, 16'h0070));
        vq.push_back(mk(0, 16'h0020, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0022, 0, 16'h0002));
        vq.push_back(mk(0, 16'h0030, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0032, 0, 16'h0002));
        vq.push_back(mk(0, 16'h0010, 1, 16'h0010, 1, 16'h0044, 0, 16'h0012, 0, 0, 16'h0012, 1, 16'h0044));
        vq.push_back(mk(0, 16'h0010, 1, 16'h0010, 0, 16'h0000, 1, 16'h0044, 1, 1, 16'h0044, 1, 16'h0012));
        vq.push_back(mk(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0012, 0, 16'h0002));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].lk, vq[i].uv, vq[i].upc, vq[i].ut, vq[i].utgt,
                  vq[i].upt, vq[i].uptgt);
            chk("lk_hit",      i, {15'd0, lk_hit},     {15'd0, vq[i].hit});
            chk("lk_taken",    i, {15'd0, lk_taken},   {15'd0, vq[i].tk});
            chk("lk_target",   i, lk_target,           vq[i].tgt);
            chk("mispredict",  i, {15'd0, mispredict}, {15'd0, vq[i].mis});
            chk("redirect_pc", i, redirect_pc,         vq[i].redir);
        end

        // Two-cycle reset hold, then a fresh allocation becomes visible one cycle later.
        drive(1, 16'h0040, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        drive(1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        chk("rst_hold_hit", 100, {15'd0, lk_hit}, 16'd0);
        drive(0, 16'h0040, 1, 16'h0040, 1, 16'h0200, 0, 16'h0042);
        chk("alloc_same_cycle", 101, {15'd0, lk_hit}, 16'd0);
        drive(0, 16'h0040, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        chk("alloc_next_target", 102, lk_target, 16'h0200);
        drive(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        chk("after_rst_old_entry", 103, {15'd0, lk_hit}, 16'd0);

`ifdef BP_STATS_EN
        drive(1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        drive(0, 16'h0000, 1, 16'h0010, 0, 16'h0000, 0, 16'h0012);
        drive(0, 16'h0000, 1, 16'h0010, 0, 16'h0000, 0, 16'h0012);
        drive(0, 16'h0000, 1, 16'h0010, 1, 16'h0040, 0, 16'h0012);
        drive(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        chk("stat_upd", 200, stat_upd, 16'd3);
        chk("stat_miss", 200, stat_miss, 16'd1);
        drive(1, 16'h0000, 1, 16'h0010, 1, 16'h0040, 0, 16'h0012);
        drive(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        chk("stat_upd_rst", 201, stat_upd, 16'd0);
        chk("stat_miss_rst", 201, stat_miss, 16'd0);
        for (int n = 0; n < 65540; n++)
            drive(0, 16'h0000, 1, 16'h0010, 1, 16'h0040, 0, 16'h0012);
        drive(0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
        chk("stat_upd_sat", 202, stat_upd, 16'hFFFF);
        chk("stat_miss_sat", 202, stat_miss, 16'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
